step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- Multi-step timed enable sequencer that sits around a one-shot delay counter, both upstream and downstream of it.
- Drives the counter's active-high restart input and consumes its one-cycle completion pulse and its running flag.
- Advances through NUM_STEPS steps, setting one enable bit per completed delay, for power-rail and peripheral bring-up on the board.
- Includes abort and a watchdog timeout in case the timer never completes.

Parameters:
NUM_STEPS, 4, number of sequence steps (2..16)
IDX_W, 4, width of step_idx; must satisfy 2^IDX_W >= NUM_STEPS
WAIT_LIMIT, 0, max clk cycles spent in WAIT before error; 0 disables the watchdog
TO_W, 16, width of the watchdog counter; WAIT_LIMIT < 2^TO_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled request to begin the sequence
abort  input  1  level-sampled request to drop all enables and return to idle
timer_done  input  1  completion pulse from the one-shot counter (may be held >1 cycle)
timer_running  input  1  high while the one-shot counter is counting
timer_restart  output  1  registered one-cycle active-high restart to the one-shot counter
step_idx  output  IDX_W  index of the step currently being timed
step_strobe  output  1  one-cycle pulse when a step completes
en_mask  output  NUM_STEPS  thermometer of completed steps; bit k set when step k completes
busy  output  1  high in ARM/WAIT
done  output  1  high in DONE
error  output  1  high in ERR

Behaviour:
- Reset (rst_n low, async): state=IDLE. All outputs 0: timer_restart, step_idx, step_strobe, en_mask, busy, done, error. done_q=0, watchdog count=0.
- States: IDLE, ARM, WAIT, DONE, ERR. All outputs are registered.
- IDLE: start=1 -> ARM next cycle; step_idx=0, en_mask=0.
- ARM (exactly 1 cycle): timer_restart=1, busy=1, watchdog cleared. -> WAIT. A timer_done edge in this cycle is ignored.
- WAIT: busy=1; edge = timer_done & ~done_q, where done_q is timer_done registered every cycle.
  - On edge: en_mask[step_idx] set and step_strobe=1, both visible the next cycle.
  - If step_idx==NUM_STEPS-1 -> DONE; else step_idx+1 and -> ARM.
  - A held-high timer_done produces exactly one step advance.
  - Latency: edge sampled at cycle n -> strobe, mask bit and new ARM visible at n+1 -> timer_restart high at n+1.
- Watchdog (WAIT_LIMIT>0): counts cycles in WAIT. When count reaches WAIT_LIMIT with no edge -> ERR.
  - An edge in the same cycle as the limit wins; the step advances.
  - timer_running is status only. It does not alter transitions but is exported for debug.
- DONE: done=1, en_mask all ones, busy=0. Holds until start (restarts: en_mask cleared, step_idx=0, -> ARM) or abort (-> IDLE).
- ERR: error=1, en_mask cleared to 0 on entry, busy=0. Leaves only on abort -> IDLE. start is ignored.
- abort=1 in any state -> IDLE next cycle: en_mask=0, step_idx=0, strobe 0, done/error 0, no timer_restart. abort beats start and beats a simultaneous timer_done edge.
- start while busy is ignored.
- step_strobe is never high for two consecutive cycles.
- timer_restart never coincides with step_strobe from the same step.
- Reset asserted mid-sequence clears everything asynchronously. Release with start held high -> ARM on the first clock edge after release.

Test Plan:
- NUM_STEPS=3, WAIT_LIMIT=0, timer model MOD=5 pulse; start 1 cycle -> timer_restart pulses 3 times, en_mask 001->011->111, step_strobe 3 single pulses, done=1 after 3rd, busy=0.
- Same setup, timer_done held high 4 cycles per step -> exactly one advance per step, en_mask ends 111, strobe count 3.
- WAIT_LIMIT=10, timer never pulses -> error=1 at cycle 11 of WAIT, en_mask=0, busy=0; then abort -> IDLE, error=0; start without abort while in ERR -> no effect.
- abort asserted in the same cycle as a step-2 timer_done edge -> next cycle IDLE, en_mask=000, step_strobe=0, no timer_restart.
- In DONE, pulse start -> en_mask=000, step_idx=0, timer_restart=1 next cycle, sequence reruns to 111. start pulsed during WAIT -> ignored, no extra restart.
- rst_n dropped mid-WAIT at step 1 -> all outputs 0 immediately, without waiting for clk. Release with start high -> ARM on the first clock edge.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: multi-step timed enable sequencer wrapped around a one-shot
// delay counter. Each completed delay sets one enable bit, then the counter is
// restarted for the next step. Abort and an optional WAIT watchdog are included.
module step_sequencer #(
  parameter int NUM_STEPS  = 4,
  parameter int IDX_W      = 4,
  parameter int WAIT_LIMIT = 0,
  parameter int TO_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 timer_done,
  input  logic                 timer_running,
  output logic                 timer_restart,
  output logic [IDX_W-1:0]     step_idx,
  output logic                 step_strobe,
  output logic [NUM_STEPS-1:0] en_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_STEPS - 1);
  localparam logic [TO_W-1:0]      WD_LIMIT = TO_W'(WAIT_LIMIT);
  localparam logic [NUM_STEPS-1:0] MASK_ONE = NUM_STEPS'(1);
  localparam bit                   WD_EN    = (WAIT_LIMIT != 0);

  state_t               r_state;
  logic                 r_done_q;
  logic [IDX_W-1:0]     r_step_idx;
  logic [NUM_STEPS-1:0] r_en_mask;
  logic                 r_step_strobe;
  logic [TO_W-1:0]      r_wd;
  logic                 r_timer_restart;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  state_t               w_state_next;
  logic [IDX_W-1:0]     w_idx_next;
  logic [NUM_STEPS-1:0] w_mask_next;
  logic                 w_strobe_next;
  logic [TO_W-1:0]      w_wd_next;
  logic [TO_W-1:0]      w_wd_inc;
  logic [NUM_STEPS-1:0] w_step_bit;
  logic                 w_edge;
  logic                 w_unused;

  // timer_running is status only; it never steers the sequence.
  assign w_unused   = timer_running;
  assign w_edge     = timer_done & ~r_done_q;
  assign w_wd_inc   = r_wd + TO_W'(1);
  assign w_step_bit = MASK_ONE << r_step_idx;

  // Next-state and next-output decode; abort overrides everything.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_step_idx;
    w_mask_next   = r_en_mask;
    w_strobe_next = 1'b0;
    w_wd_next     = r_wd;
    if (abort) begin
      w_state_next = S_IDLE;
      w_idx_next   = '0;
      w_mask_next  = '0;
      w_wd_next    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_idx_next  = '0;
          w_mask_next = '0;
          if (start) begin
            w_state_next = S_ARM;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_ARM: begin
          // Restart is being issued this cycle; any done edge here is stale.
          w_wd_next    = '0;
          w_state_next = S_WAIT;
        end
        S_WAIT: begin
          if (w_edge) begin
            // A completion edge wins over a simultaneous watchdog expiry.
            w_mask_next   = r_en_mask | w_step_bit;
            w_strobe_next = 1'b1;
            if (r_step_idx == LAST_IDX) begin
              w_state_next = S_DONE;
            end else begin
              w_idx_next   = r_step_idx + IDX_W'(1);
              w_state_next = S_ARM;
            end
          end else begin
            w_wd_next = w_wd_inc;
            if (WD_EN && (w_wd_inc == WD_LIMIT)) begin
              w_state_next = S_ERR;
              w_mask_next  = '0;
            end else begin
              w_state_next = S_WAIT;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            w_state_next = S_ARM;
            w_idx_next   = '0;
            w_mask_next  = '0;
          end else begin
            w_state_next = S_DONE;
          end
        end
        S_ERR: begin
          // Only abort leaves ERR; enables stay dropped.
          w_mask_next  = '0;
          w_state_next = S_ERR;
        end
        default: begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
          w_mask_next  = '0;
          w_wd_next    = '0;
        end
      endcase
    end
  end

  // State, edge-detect history and registered outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_done_q        <= 1'b0;
      r_step_idx      <= '0;
      r_en_mask       <= '0;
      r_step_strobe   <= 1'b0;
      r_wd            <= '0;
      r_timer_restart <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_done_q        <= timer_done;
      r_step_idx      <= w_idx_next;
      r_en_mask       <= w_mask_next;
      r_step_strobe   <= w_strobe_next;
      r_wd            <= w_wd_next;
      r_timer_restart <= (w_state_next == S_ARM);
      r_busy          <= (w_state_next == S_ARM) || (w_state_next == S_WAIT);
      r_done          <= (w_state_next == S_DONE);
      r_error         <= (w_state_next == S_ERR);
    end
  end

  assign timer_restart = r_timer_restart;
  assign step_idx      = r_step_idx;
  assign step_strobe   = r_step_strobe;
  assign en_mask       = r_en_mask;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed bench for step_sequencer with a behavioural
// one-shot timer model. Instance a has a 10-cycle watchdog, instance b none.
module tb_step_sequencer;

  localparam int NS  = 3;
  localparam int IW  = 2;
  localparam int WL  = 10;
  localparam int TW  = 16;
  localparam int MOD = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          timer_done;
  logic          timer_running;

  logic          a_timer_restart, b_timer_restart;
  logic [IW-1:0] a_step_idx, b_step_idx;
  logic          a_step_strobe, b_step_strobe;
  logic [NS-1:0] a_en_mask, b_en_mask;
  logic          a_busy, b_busy;
  logic          a_done, b_done;
  logic          a_error, b_error;

  int n_checks = 0;
  int n_errors = 0;
  int n_restart = 0;
  int n_strobe = 0;
  int t_cnt;
  int t_hold;
  int hold_len;
  bit t_fire;

  step_sequencer #(.NUM_STEPS(NS), .IDX_W(IW), .WAIT_LIMIT(WL), .TO_W(TW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .timer_done(timer_done), .timer_running(timer_running),
    .timer_restart(a_timer_restart), .step_idx(a_step_idx), .step_strobe(a_step_strobe),
    .en_mask(a_en_mask), .busy(a_busy), .done(a_done), .error(a_error)
  );

  step_sequencer #(.NUM_STEPS(NS), .IDX_W(IW), .WAIT_LIMIT(0), .TO_W(TW)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .timer_done(timer_done), .timer_running(timer_running),
    .timer_restart(b_timer_restart), .step_idx(b_step_idx), .step_strobe(b_step_strobe),
    .en_mask(b_en_mask), .busy(b_busy), .done(b_done), .error(b_error)
  );

  always #5 clk = ~clk;

  // One-shot timer model: MOD cycles after a restart, raise done for hold_len cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt         <= 0;
      t_hold        <= 0;
      timer_done    <= 1'b0;
      timer_running <= 1'b0;
    end else begin
      if (t_hold > 0) begin
        t_hold <= t_hold - 1;
        if (t_hold == 1) timer_done <= 1'b0;
      end
      if (a_timer_restart) begin
        t_cnt         <= MOD;
        timer_running <= 1'b1;
      end else if (t_cnt > 0) begin
        t_cnt <= t_cnt - 1;
        if (t_cnt == 1) begin
          timer_running <= 1'b0;
          if (t_fire) begin
            timer_done <= 1'b1;
            t_hold     <= hold_len;
          end
        end
      end
    end
  end

  // Running totals of restart and strobe pulses on instance a.
  always @(posedge clk) begin
    if (a_timer_restart === 1'b1) n_restart++;
    if (a_step_strobe === 1'b1) n_strobe++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait for done, checking mask growth, restart alongside each inner strobe,
  // and that strobes never come back to back.
  task automatic run_to_done(input string tag);
    int  k;
    int  dbl;
    bit  prev;
    k = 0; dbl = 0; prev = 1'b0;
    for (int t = 0; t < 200 && a_done !== 1'b1; t++) begin
      tick();
      if (a_step_strobe === 1'b1) begin
        check_eq({tag, "_mask"}, 32'(a_en_mask), (32'd1 << (k + 1)) - 32'd1);
        if (a_done !== 1'b1) check_eq({tag, "_restart_after_strobe"}, 32'(a_timer_restart), 32'd1);
        if (prev) dbl++;
        k++;
      end
      prev = (a_step_strobe === 1'b1);
    end
    check_eq({tag, "_done"}, 32'(a_done), 32'd1);
    check_eq({tag, "_busy"}, 32'(a_busy), 32'd0);
    check_eq({tag, "_mask_full"}, 32'(a_en_mask), 32'd7);
    check_eq({tag, "_strobes"}, 32'(k), 32'd3);
    check_eq({tag, "_double_strobe"}, 32'(dbl), 32'd0);
  endtask

  // Pulse start and wait (bounded) for the first step strobe.
  task automatic start_to_first_strobe(input string tag);
    bit found;
    found = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      tick();
      if (a_step_strobe === 1'b1) found = 1'b1;
    end
    check_eq({tag, "_first_strobe"}, 32'(found), 32'd1);
  endtask

  initial begin
    int  base;
    bit  found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; t_fire = 1'b1; hold_len = 1;

    // Reset state
    tick(); tick();
    check_eq("reset_a", 32'({a_timer_restart, a_step_idx, a_step_strobe, a_en_mask, a_busy, a_done, a_error}), 32'd0);
    check_eq("reset_b", 32'({b_timer_restart, b_step_idx, b_step_strobe, b_en_mask, b_busy, b_done, b_error}), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", 32'(a_busy), 32'd0);

    // Basic three-step run with single-cycle done pulses
    base = n_restart;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("arm_restart", 32'(a_timer_restart), 32'd1);
    check_eq("arm_busy", 32'(a_busy), 32'd1);
    check_eq("arm_idx", 32'(a_step_idx), 32'd0);
    run_to_done("basic");
    tick();
    check_eq("basic_restarts", 32'(n_restart - base), 32'd3);

    // Held timer_done: one advance per step
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_done_clr", 32'(a_done), 32'd0);
    check_eq("abort_mask_clr", 32'(a_en_mask), 32'd0);
    hold_len = 4;
    base = n_restart;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("hold");
    repeat (5) tick();
    check_eq("hold_restarts", 32'(n_restart - base), 32'd3);
    hold_len = 1;

    // Restart from DONE, plus start during WAIT is ignored
    base = n_restart;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rerun_mask", 32'(a_en_mask), 32'd0);
    check_eq("rerun_idx", 32'(a_step_idx), 32'd0);
    check_eq("rerun_restart", 32'(a_timer_restart), 32'd1);
    check_eq("rerun_done", 32'(a_done), 32'd0);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wait_start_ignored", 32'(a_timer_restart), 32'd0);
    run_to_done("rerun");
    tick();
    check_eq("rerun_restarts", 32'(n_restart - base), 32'd3);

    // Abort coinciding with the step-2 completion edge
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      tick();
      if (timer_done === 1'b1 && a_step_idx == 2'd1) found = 1'b1;
    end
    check_eq("abort_edge_found", 32'(found), 32'd1);
    check_eq("abort_pre_mask", 32'(a_en_mask), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_edge_mask", 32'(a_en_mask), 32'd0);
    check_eq("abort_edge_strobe", 32'(a_step_strobe), 32'd0);
    check_eq("abort_edge_restart", 32'(a_timer_restart), 32'd0);
    check_eq("abort_edge_busy", 32'(a_busy), 32'd0);
    check_eq("abort_edge_idx", 32'(a_step_idx), 32'd0);
    base = n_restart;
    repeat (3) tick();
    check_eq("abort_no_restart", 32'(n_restart - base), 32'd0);

    // Watchdog: step 1 completes, step 2 timer never fires
    start_to_first_strobe("wd");
    t_fire = 1'b0;
    repeat (10) tick();
    check_eq("wd_w10_error", 32'(a_error), 32'd0);
    check_eq("wd_w10_busy", 32'(a_busy), 32'd1);
    check_eq("wd_w10_mask", 32'(a_en_mask), 32'd1);
    tick();
    check_eq("wd_err", 32'(a_error), 32'd1);
    check_eq("wd_err_busy", 32'(a_busy), 32'd0);
    check_eq("wd_err_mask", 32'(a_en_mask), 32'd0);
    check_eq("wd_err_done", 32'(a_done), 32'd0);
    check_eq("nowd_error", 32'(b_error), 32'd0);
    check_eq("nowd_busy", 32'(b_busy), 32'd1);
    check_eq("nowd_mask", 32'(b_en_mask), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("err_start_error", 32'(a_error), 32'd1);
    check_eq("err_start_restart", 32'(a_timer_restart), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("err_abort_error", 32'(a_error), 32'd0);
    check_eq("err_abort_busy", 32'(a_busy), 32'd0);
    t_fire = 1'b1;

    // Async reset in WAIT of step 1, release with start held
    start_to_first_strobe("rst");
    tick(); tick();
    check_eq("rst_pre_busy", 32'(a_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_a", 32'({a_timer_restart, a_step_idx, a_step_strobe, a_en_mask, a_busy, a_done, a_error}), 32'd0);
    check_eq("async_rst_b", 32'({b_timer_restart, b_step_idx, b_step_strobe, b_en_mask, b_busy, b_done, b_error}), 32'd0);
    start = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rel_restart", 32'(a_timer_restart), 32'd1);
    check_eq("rel_busy", 32'(a_busy), 32'd1);
    check_eq("rel_idx", 32'(a_step_idx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
